// File: rtl/cp_apb_host.sv
// cp_apb_host: APB initiator running one cipher job end to end.
// Define CP_HOST_TIMEOUT_EN to bound the interrupt wait with a watchdog.
module cp_apb_host #(
  parameter logic [15:0] P_TIMEOUT = 16'd4096
) (
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iJobSt,
  input  logic [11:0]  iByteSize,
  input  logic [127:0] iKey,
  output logic         oBusy,
  output logic         oJobDone,
  output logic         oErr,
  output logic         oSrcRd,
  input  logic [31:0]  iSrcDt,
  output logic         oDstWr,
  output logic [31:0]  oDstDt,
  output logic         oPsel,
  output logic         oPenable,
  output logic         oPwrite,
  output logic [15:0]  oPaddr,
  output logic [31:0]  oPwdata,
  input  logic [31:0]  iPrdata,
  input  logic         iPready,
  input  logic         iInt
);

  localparam logic [15:0] P_ADDR_KEY    = 16'h0010;
  localparam logic [15:0] P_ADDR_SIZE   = 16'h0020;
  localparam logic [15:0] P_ADDR_START  = 16'h0024;
  localparam logic [15:0] P_ADDR_INTCLR = 16'h0028;
  localparam logic [15:0] P_ADDR_INBUF  = 16'h1000;
  localparam logic [15:0] P_ADDR_OUTBUF = 16'h2000;

  typedef enum logic [3:0] {
    IDLE, KEY, DIN, CFG, GO, WAIT, DOUT, CLR, DONE
  } stateT;

  typedef enum logic [1:0] {
    S_GAP, S_SETUP, S_ACCESS
  } stepT;

  stateT        state, stateN, nxt;
  stepT         step, stepN;
  logic [9:0]   idx, idxN;
  logic [9:0]   nWords;
  logic [11:0]  sizeReg;
  logic [127:0] keyReg;
  logic [31:0]  srcWord;
  logic [31:0]  keyWord;
  logic [11:0]  sizeC;
  logic [9:0]   nCalc;
  logic         apbPh;
  logic         last;
  logic         xferDone;
  logic         accept;

  assign sizeC  = (iByteSize > 12'd2048) ? 12'd2048 : iByteSize;
  assign nCalc  = 10'((sizeC + 12'd3) >> 2);
  assign accept = (state == IDLE) && iJobSt;

`ifdef CP_HOST_TIMEOUT_EN
  logic        errReg, errN;
  logic [15:0] cnt, cntN;
`endif

  always_comb begin
    stateN   = state;
    stepN    = step;
    idxN     = idx;
    nxt      = IDLE;
    last     = 1'b1;
    apbPh    = 1'b0;
    xferDone = (step == S_ACCESS) && iPready;
`ifdef CP_HOST_TIMEOUT_EN
    errN     = errReg;
`endif
    unique case (state)
      KEY: begin
        apbPh = 1'b1;
        last  = (idx == 10'd3);
        nxt   = DIN;
      end
      DIN: begin
        apbPh = 1'b1;
        last  = (idx == nWords - 10'd1);
        nxt   = CFG;
      end
      CFG: begin
        apbPh = 1'b1;
        nxt   = GO;
      end
      GO: begin
        apbPh = 1'b1;
        nxt   = WAIT;
      end
      DOUT: begin
        apbPh = 1'b1;
        last  = (idx == nWords - 10'd1);
        nxt   = CLR;
      end
      CLR: begin
        apbPh = 1'b1;
        nxt   = DONE;
      end
      default: ;
    endcase

    if (state == IDLE) begin
      if (iJobSt) begin
        stateN = KEY;
        stepN  = S_GAP;
        idxN   = '0;
`ifdef CP_HOST_TIMEOUT_EN
        errN   = 1'b0;
`endif
      end
    end else if (state == KEY && sizeReg == 12'd0) begin
      stateN = DONE;
    end else if (state == WAIT) begin
      if (iInt) begin
        stateN = DOUT;
        stepN  = S_GAP;
        idxN   = '0;
      end
`ifdef CP_HOST_TIMEOUT_EN
      else if (cnt == P_TIMEOUT - 16'd1) begin
        stateN = CLR;
        stepN  = S_GAP;
        errN   = 1'b1;
      end
`endif
    end else if (state == DONE) begin
      stateN = IDLE;
    end else if (apbPh) begin
      unique case (step)
        S_GAP:   stepN = S_SETUP;
        S_SETUP: stepN = S_ACCESS;
        S_ACCESS: begin
          if (iPready) begin
            if (last) begin
              stateN = nxt;
              stepN  = S_GAP;
              idxN   = '0;
            end else begin
              stepN  = S_SETUP;
              idxN   = idx + 10'd1;
            end
          end
        end
        default: stepN = S_GAP;
      endcase
    end
  end

`ifdef CP_HOST_TIMEOUT_EN
  assign cntN = (state == WAIT && stateN == WAIT) ? cnt + 16'd1 : 16'd0;
  assign oErr = (state == DONE) && errReg;
`else
  assign oErr = 1'b0;
`endif

  assign oBusy    = (state != IDLE) && (state != DONE);
  assign oJobDone = (state == DONE);
  assign oPsel    = apbPh && (step != S_GAP);
  assign oPenable = apbPh && (step == S_ACCESS);
  assign oPwrite  = oPsel && (state != DOUT);
  // head word is fetched in the gap and on each non-final completion
  assign oSrcRd   = (state == DIN) &&
                    ((step == S_GAP) || (xferDone && !last));

  always_comb begin
    unique case (idx[1:0])
      2'd0: keyWord = keyReg[127:96];
      2'd1: keyWord = keyReg[95:64];
      2'd2: keyWord = keyReg[63:32];
      2'd3: keyWord = keyReg[31:0];
    endcase
  end

  always_comb begin
    oPaddr  = '0;
    oPwdata = '0;
    if (oPsel) begin
      unique case (state)
        KEY: begin
          oPaddr  = P_ADDR_KEY + {12'd0, idx[1:0], 2'b00};
          oPwdata = keyWord;
        end
        DIN: begin
          oPaddr  = P_ADDR_INBUF + {4'd0, idx, 2'b00};
          oPwdata = srcWord;
        end
        CFG: begin
          oPaddr  = P_ADDR_SIZE;
          oPwdata = {20'd0, sizeReg};
        end
        GO: begin
          oPaddr  = P_ADDR_START;
          oPwdata = 32'd1;
        end
        DOUT: oPaddr = P_ADDR_OUTBUF + {4'd0, idx, 2'b00};
        CLR: begin
          oPaddr  = P_ADDR_INTCLR;
          oPwdata = 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state   <= IDLE;
      step    <= S_GAP;
      idx     <= '0;
      nWords  <= '0;
      sizeReg <= '0;
      keyReg  <= '0;
      srcWord <= '0;
      oDstWr  <= 1'b0;
      oDstDt  <= '0;
`ifdef CP_HOST_TIMEOUT_EN
      errReg  <= 1'b0;
      cnt     <= '0;
`endif
    end else begin
      state  <= stateN;
      step   <= stepN;
      idx    <= idxN;
      oDstWr <= (state == DOUT) && xferDone;
      if (accept) begin
        keyReg  <= iKey;
        sizeReg <= sizeC;
        nWords  <= nCalc;
      end
      if (oSrcRd)
        srcWord <= iSrcDt;
      if (state == DOUT && xferDone)
        oDstDt <= iPrdata;
`ifdef CP_HOST_TIMEOUT_EN
      errReg <= errN;
      cnt    <= cntN;
`endif
    end
  end

endmodule

// File: tb/tb_cp_apb_host.sv
// tb_cp_apb_host: directed jobs against an APB slave / FIFO model.
// Define CP_HOST_TIMEOUT_EN to add the watchdog job (P_TIMEOUT=100).
module tb_cp_apb_host;

  logic         iClk = 1'b0;
  logic         iRsn = 1'b0;
  logic         iJobSt = 1'b0;
  logic [11:0]  iByteSize = '0;
  logic [127:0] iKey = '0;
  logic         oBusy, oJobDone, oErr, oSrcRd, oDstWr;
  logic [31:0]  iSrcDt = 32'hA500_0000;
  logic [31:0]  oDstDt;
  logic         oPsel, oPenable, oPwrite;
  logic [15:0]  oPaddr;
  logic [31:0]  oPwdata;
  logic [31:0]  iPrdata = '0;
  logic         iPready = 1'b0;
  logic         iInt = 1'b0;

  cp_apb_host #(.P_TIMEOUT(16'd100)) dut (
    .iClk(iClk), .iRsn(iRsn), .iJobSt(iJobSt),
    .iByteSize(iByteSize), .iKey(iKey),
    .oBusy(oBusy), .oJobDone(oJobDone), .oErr(oErr),
    .oSrcRd(oSrcRd), .iSrcDt(iSrcDt),
    .oDstWr(oDstWr), .oDstDt(oDstDt),
    .oPsel(oPsel), .oPenable(oPenable), .oPwrite(oPwrite),
    .oPaddr(oPaddr), .oPwdata(oPwdata),
    .iPrdata(iPrdata), .iPready(iPready), .iInt(iInt)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [63:0] txnQ[$];
  int          stampQ[$];
  logic [31:0] dstQ[$];
  logic [63:0] expQ[$];
  int cyc = 0, pselCyc = 0, unstable = 0;
  int wcnt = 0, pWait = 0, intDelay = -1, intCnt = 0;
  int srcIdx = 0, popCnt = 0, doneCnt = 0, doneStamp = 0;
  logic doneErr = 1'b0;
  logic popped = 1'b0;
  logic [15:0] sAddr = '0;
  logic [31:0] sData = '0;
  logic sWr = 1'b0;

  always @(posedge iClk) popped = oSrcRd;

  always @(negedge iClk) begin
    cyc++;
    if (intCnt > 0) begin
      intCnt--;
      if (intCnt == 0) iInt = 1'b1;
    end
    if (oPsel) pselCyc++;
    if (oPsel && !oPenable) begin
      sAddr = oPaddr;
      sWr   = oPwrite;
      sData = oPwdata;
    end
    if (oPsel && oPenable) begin
      if (oPaddr !== sAddr || oPwrite !== sWr ||
          (oPwrite && oPwdata !== sData))
        unstable++;
      iPrdata = {16'hC0DE, oPaddr};
      if (wcnt >= pWait) begin
        iPready = 1'b1;
        wcnt = 0;
        txnQ.push_back({15'd0, oPwrite, oPaddr,
                        oPwrite ? oPwdata : iPrdata});
        stampQ.push_back(cyc);
        if (oPwrite && oPaddr == 16'h0024) begin
          if (intDelay == 0) iInt = 1'b1;
          else if (intDelay > 0) intCnt = intDelay;
        end
        if (oPwrite && oPaddr == 16'h0028) iInt = 1'b0;
      end else begin
        iPready = 1'b0;
        wcnt++;
      end
    end else begin
      iPready = 1'b0;
      wcnt = 0;
    end
    if (popped) begin
      srcIdx++;
      popCnt++;
      iSrcDt = 32'hA500_0000 + 32'(srcIdx);
    end
    if (oDstWr) dstQ.push_back(oDstDt);
    if (oJobDone) begin
      doneCnt++;
      doneErr = oErr;
      doneStamp = cyc;
    end
  end

  task automatic clearLogs();
    txnQ.delete();
    stampQ.delete();
    dstQ.delete();
    expQ.delete();
    pselCyc = 0;
    unstable = 0;
    popCnt = 0;
    doneCnt = 0;
    intCnt = 0;
  endtask

  task automatic runJob(input logic [11:0] size, input logic [127:0] key,
                        input int waitN, input int intDel, input bit inj,
                        input bit expErr, input int expGap);
    int sc, n, base, startStamp, goIdx;
    bit injected;
    logic [15:0] a;
    clearLogs();
    pWait = waitN;
    intDelay = intDel;
    base = srcIdx;
    injected = 0;
    sc = (size > 12'd2048) ? 2048 : int'(size);
    n = (sc + 3) / 4;
    if (sc != 0) begin
      for (int k = 0; k < 4; k++)
        expQ.push_back({15'd0, 1'b1, 16'(16'h0010 + 4 * k),
                        key[127 - 32 * k -: 32]});
      for (int i = 0; i < n; i++)
        expQ.push_back({15'd0, 1'b1, 16'(16'h1000 + 4 * i),
                        32'(32'hA500_0000 + base + i)});
      expQ.push_back({15'd0, 1'b1, 16'h0020, 32'(sc)});
      expQ.push_back({15'd0, 1'b1, 16'h0024, 32'd1});
      if (!expErr)
        for (int i = 0; i < n; i++) begin
          a = 16'(16'h2000 + 4 * i);
          expQ.push_back({15'd0, 1'b0, a, 16'hC0DE, a});
        end
      expQ.push_back({15'd0, 1'b1, 16'h0028, 32'd1});
    end
    iByteSize = size;
    iKey = key;
    iJobSt = 1'b1;
    startStamp = cyc;
    @(negedge iClk); #1;
    iJobSt = 1'b0;
    check("busyRise", 64'(oBusy), 64'd1);
    for (int c = 0; c < 40000 && doneCnt == 0; c++) begin
      if (inj && !injected && popCnt == 1) begin
        iJobSt = 1'b1;
        iByteSize = 12'd100;
        injected = 1;
      end else begin
        iJobSt = 1'b0;
        iByteSize = size;
      end
      @(negedge iClk); #1;
    end
    iJobSt = 1'b0;
    check("doneSeen", 64'(doneCnt), 64'd1);
    check("err", 64'(doneErr), 64'(expErr));
    if (size == 12'd0) begin
      check("zeroLat", 64'(doneStamp - startStamp), 64'd2);
      check("zeroPsel", 64'(pselCyc), 64'd0);
    end
    check("txnCount", 64'(txnQ.size()), 64'(expQ.size()));
    for (int i = 0; i < txnQ.size() && i < expQ.size(); i++)
      check("txn", txnQ[i], expQ[i]);
    check("srcRd", 64'(popCnt), 64'(n));
    check("dstWr", 64'(dstQ.size()), expErr ? 64'd0 : 64'(n));
    for (int i = 0; i < dstQ.size() && i < n; i++)
      check("dstDt", 64'(dstQ[i]), {32'd0, 16'hC0DE, 16'(16'h2000 + 4 * i)});
    check("stable", 64'(unstable), 64'd0);
    goIdx = 4 + n + 1;
    if (expGap >= 0) begin
      if (stampQ.size() > goIdx + 1)
        check("waitGap", 64'(stampQ[goIdx + 1] - stampQ[goIdx]), 64'(expGap));
      else
        check("waitGapTxn", 64'(stampQ.size()), 64'(goIdx + 2));
    end
    @(negedge iClk); #1;
    check("busyEnd", 64'(oBusy), 64'd0);
    repeat (3) @(negedge iClk);
    #1;
    check("donePulse", 64'(doneCnt), 64'd1);
  endtask

  initial begin
    bit found;
    #1;
    check("rstCtl", 64'({oBusy, oJobDone, oErr, oSrcRd, oDstWr,
                          oPsel, oPenable, oPwrite}), 64'd0);
    check("rstData", {oPaddr, oPwdata, 16'd0}, 64'd0);
    repeat (2) @(negedge iClk);
    #1;
    iRsn = 1'b1;
    @(negedge iClk); #1;

    runJob(12'd16, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
           0, 10, 0, 0, 13);
    runJob(12'd5, 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0,
           3, 0, 0, 0, -1);
    check("waitPsel", 64'(pselCyc), 64'd55);
    runJob(12'd0, 128'h1, 0, 0, 0, 0, -1);
    runJob(12'd4000, 128'hCAFE_0000_CAFE_1111_CAFE_2222_CAFE_3333,
           0, 2, 0, 0, -1);
    runJob(12'd16, 128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444,
           0, 10, 1, 0, 13);
    runJob(12'd4, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
           0, 0, 0, 0, 4);

    clearLogs();
    pWait = 3;
    intDelay = 0;
    iByteSize = 12'd8;
    iKey = 128'h5;
    iJobSt = 1'b1;
    @(negedge iClk); #1;
    iJobSt = 1'b0;
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge iClk); #1;
      if (oPsel && oPenable && !oPwrite) found = 1;
    end
    check("doutSeen", 64'(found), 64'd1);
    iRsn = 1'b0;
    #1;
    check("rstMidCtl", 64'({oBusy, oJobDone, oErr, oSrcRd, oDstWr,
                             oPsel, oPenable, oPwrite}), 64'd0);
    check("rstMidData", {oPaddr, oPwdata, 16'd0}, 64'd0);
    check("rstMidDst", 64'(oDstDt), 64'd0);
    iInt = 1'b0;
    @(negedge iClk); #1;
    check("rstIdle", 64'(oBusy), 64'd0);
    iRsn = 1'b1;
    @(negedge iClk); #1;
    check("rstHold", 64'({oBusy, oPsel}), 64'd0);
    runJob(12'd8, 128'h7777_6666_5555_4444_3333_2222_1111_0000,
           0, 10, 0, 0, 13);

`ifdef CP_HOST_TIMEOUT_EN
    runJob(12'd8, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000,
           0, -1, 0, 1, 103);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp_apb_host.md
# cp_apb_host

APB initiator that runs one complete cipher job against the cipher peripheral's APB register file. On a start pulse it writes the 128-bit key and N input words, programs the byte size, and triggers the cipher. It then waits for the peripheral interrupt, reads N result words back, and clears the interrupt. It sits on the host side of the APB link, between a show-ahead source FIFO, a sink FIFO and the peripheral's APB slave port.

## Interface
- P_ADDR_KEY, 16'h0010: byte address of key word 0; key words 1..3 at +4, +8, +12.
- P_ADDR_SIZE, 16'h0020: byte-size register.
- P_ADDR_START, 16'h0024: start register; written with 32'h1.
- P_ADDR_INTCLR, 16'h0028: interrupt clear; written with 32'h1.
- P_ADDR_INBUF, 16'h1000: input buffer base; word i at base + 4*i.
- P_ADDR_OUTBUF, 16'h2000: output buffer base; word i at base + 4*i.
- P_TIMEOUT, 16'd4096: watchdog limit in cycles (CP_HOST_TIMEOUT_EN only).

Ports (one clock; reset is asynchronous and active-low):
- iClk, in, 1: clock, rising edge.
- iRsn, in, 1: asynchronous active-low reset.
- iJobSt, in, 1: job start pulse; ignored while oBusy=1.
- iByteSize, in, 12: job byte size; latched on the accepted iJobSt.
- iKey, in, 128: cipher key; latched on the accepted iJobSt.
- oBusy, out, 1: job in progress.
- oJobDone, out, 1: one-cycle end-of-job pulse.
- oErr, out, 1: valid with oJobDone; 1 means the job timed out.
- oSrcRd, out, 1: pop the source FIFO.
- iSrcDt, in, 32: source FIFO head word (show-ahead).
- oDstWr, out, 1: push to the sink FIFO.
- oDstDt, out, 32: sink data.
- oPsel, oPenable, oPwrite, out, 1 each: APB control.
- oPaddr, out, 16: APB address.
- oPwdata, out, 32: APB write data.
- iPrdata, in, 32: APB read data.
- iPready, in, 1: APB ready.
- iInt, in, 1: peripheral interrupt, level, active high.

## Operation
- Reset value of every output is 0. The FSM resets to IDLE.
- Word count: N = (size+3)>>2, with size clamped to 2048, so N ≤ 512. N uses a 10-bit counter.
- IDLE → KEY on iJobSt:
  - oBusy rises in the next cycle.
  - If size = 0, go straight to DONE with no APB traffic.
- KEY: 4 writes. Key word k = iKey[127-32k -: 32], written to P_ADDR_KEY + 4k.
- DIN: N writes to P_ADDR_INBUF + 4i.
  - oSrcRd pulses for one cycle immediately before each SETUP cycle.
  - iSrcDt is sampled at that same edge and driven on oPwdata through SETUP and ACCESS.
- CFG: write the clamped size, zero-extended to 32 bits, to P_ADDR_SIZE.
- GO: write 1 to P_ADDR_START.
- WAIT: no APB traffic; leave when iInt=1 is sampled.
- DOUT: N reads from P_ADDR_OUTBUF + 4i.
  - iPrdata is captured on the completing ACCESS cycle.
  - In the next cycle oDstWr=1 and oDstDt = captured word.
- CLR: write 1 to P_ADDR_INTCLR.
- DONE: oJobDone=1 for one cycle, oBusy cleared in the same cycle, then → IDLE.
- A new iJobSt is accepted the cycle after DONE.

## Timing
- Each transfer is SETUP then ACCESS:
  - SETUP: oPsel=1, oPenable=0.
  - ACCESS: oPsel=1, oPenable=1.
- ACCESS is held while iPready=0. oPaddr, oPwrite and oPwdata stay stable from SETUP until completion.
- Transfer completes on the ACCESS cycle with iPready=1.
- Back-to-back within a phase: the next SETUP follows completion directly, so the minimum is 2 cycles per transfer.
- Every phase change (KEY→DIN, DIN→CFG, etc.) inserts one idle cycle with oPsel=0. This is where the first DIN oSrcRd pulse occurs.
- Minimum job latency with zero-wait slave, excluding WAIT: 1 + 4·2 + N·2 + 2 + 2 + N·2 + 2 + phase gaps.
- iInt already high on entry to WAIT: leave after one cycle.
- iJobSt while busy: ignored, no state change.
- Reset asserted mid-transfer: all outputs drop to 0 asynchronously and the transfer is abandoned. Recovery is the slave's concern.

## Configuration
- CP_HOST_TIMEOUT_EN defined:
  - A 16-bit counter runs in WAIT.
  - When it reaches P_TIMEOUT with iInt still 0, go to CLR and finish with oErr=1; DOUT is skipped.
  - The counter clears on leaving WAIT.
- CP_HOST_TIMEOUT_EN undefined: WAIT is unbounded, and oErr is tied to 0.

## Test plan
- Job with size=16, zero-wait slave, iInt raised 10 cycles after the START write:
  - Writes in order: 0x0010, 0x0014, 0x0018, 0x001C, 0x1000–0x100C, 0x0020 (data 16), 0x0024 (data 1).
  - Then reads 0x2000–0x200C, then writes 0x0028 (data 1).
  - 4 oSrcRd, 4 oDstWr, one oJobDone with oErr=0.
- size=5, with iPready low for 3 cycles on every ACCESS:
  - N=2, signals stable while waiting, each transfer takes 5 cycles.
- size=0: oJobDone two cycles after iJobSt, oPsel never asserted.
- size=4000: clamped; SIZE write data = 2048, with 512 DIN writes and 512 DOUT reads.
- iJobSt pulsed during DIN: ignored, sequence unchanged. Reset asserted during DOUT ACCESS: all outputs 0 in the same cycle, FSM in IDLE.
- With CP_HOST_TIMEOUT_EN and P_TIMEOUT=100, iInt never raised:
  - Interrupt-clear write after 100 WAIT cycles, no reads.
  - oJobDone with oErr=1.
